mbt_leaf_match: RTL

Parametrised, multi-lane leaf-node rule matcher for the MBitTree classifier. It follows the last tree level and replaces the fixed dual-port, 8-rule parallel match and priority stage. Each lane takes a packet header and leaf descriptor, then walks the leaf's rule groups in an external rule memory, `RPC` rules per beat. It stops at the first matching beat and returns the highest-priority matching rule ID, using valid/ready handshakes on both sides.

---
 rtl/mbt_pkg.sv | 37 +++
 rtl/mbt_leaf_lane.sv | 159 +++++++++++++++
 rtl/mbt_leaf_match.sv | 58 +++++
 3 files changed

// File: rtl/mbt_pkg.sv
// Shared definitions for the MBitTree leaf matcher.
// Rule slot layout (LSB first): value[PACKET_WIDTH], mask[PACKET_WIDTH], id[RULE_ID].
// Slot 0 of a memory word sits in the LSBs and has the highest priority.
package mbt_pkg;

  localparam int unsigned VAL_OFF = 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } lane_state_e;

  // Width of a rule counter that can hold 0..max_rules.
  function automatic int unsigned cnt_w(input int unsigned max_rules);
    return 32'($clog2(max_rules + 1));
  endfunction

  function automatic int unsigned rule_w(input int unsigned pw, input int unsigned idw);
    return 2 * pw + idw;
  endfunction

  function automatic int unsigned word_w(input int unsigned rpc, input int unsigned pw,
                                         input int unsigned idw);
    return rpc * rule_w(pw, idw);
  endfunction

  function automatic int unsigned mask_off(input int unsigned pw);
    return pw;
  endfunction

  function automatic int unsigned id_off(input int unsigned pw);
    return 2 * pw;
  endfunction

endpackage

// File: rtl/mbt_leaf_lane.sv
// One leaf-match lane: accepts a header + leaf descriptor, walks the leaf's rule
// words one beat at a time and reports the highest-priority matching rule.
// Ports: in_valid/in_ready request handshake (packet_in, leaf_base, leaf_nrules);
//        rd_en/rd_addr rule-memory read, rd_data returned one cycle later;
//        out_valid/out_ready result handshake (rule_id, is_matched).
module mbt_leaf_lane
  import mbt_pkg::*;
#(
  parameter  int unsigned PACKET_WIDTH = 104,
  parameter  int unsigned RULE_ID      = 14,
  parameter  int unsigned LEAF_ADDR    = 12,
  parameter  int unsigned RPC          = 4,
  parameter  int unsigned MAX_RULES    = 16,
  localparam int unsigned CNT_W        = cnt_w(MAX_RULES),
  localparam int unsigned RULE_W       = rule_w(PACKET_WIDTH, RULE_ID),
  localparam int unsigned WORD_W       = word_w(RPC, PACKET_WIDTH, RULE_ID)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PACKET_WIDTH-1:0] packet_in,
  input  logic [LEAF_ADDR-1:0]    leaf_base,
  input  logic [CNT_W-1:0]        leaf_nrules,
  output logic                    rd_en,
  output logic [LEAF_ADDR-1:0]    rd_addr,
  input  logic [WORD_W-1:0]       rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RULE_ID-1:0]      rule_id,
  output logic                    is_matched
);

  localparam int unsigned MASK_OFF = mask_off(PACKET_WIDTH);
  localparam int unsigned ID_OFF   = id_off(PACKET_WIDTH);

  lane_state_e             state_q, state_d;
  logic [PACKET_WIDTH-1:0] pkt_q, pkt_d;
  logic [LEAF_ADDR-1:0]    base_q, base_d;
  logic [CNT_W-1:0]        n_q, n_d;
  logic [CNT_W-1:0]        beat_q, beat_d;
  logic [CNT_W-1:0]        n_in_c;
  logic                    rd_en_d, out_valid_d, is_matched_d;
  logic [LEAF_ADDR-1:0]    rd_addr_d;
  logic [RULE_ID-1:0]      rule_id_d;
  logic                    hit_c, last_beat_c;
  logic [RULE_ID-1:0]      hit_id_c;

  assign in_ready = (state_q == S_IDLE);

  // Leaf rule count clamped to the per-leaf maximum.
  assign n_in_c = (leaf_nrules > CNT_W'(MAX_RULES)) ? CNT_W'(MAX_RULES) : leaf_nrules;

  // Ternary compare of all slots in the current word; lowest active hitting slot wins.
  always_comb begin
    hit_c    = 1'b0;
    hit_id_c = '0;
    for (int unsigned s = 0; s < RPC; s++) begin
      if (!hit_c &&
          (32'(beat_q) * RPC + 32'(s) < 32'(n_q)) &&
          (((pkt_q ^ rd_data[s*RULE_W + VAL_OFF +: PACKET_WIDTH]) &
            rd_data[s*RULE_W + MASK_OFF +: PACKET_WIDTH]) == '0)) begin
        hit_c    = 1'b1;
        hit_id_c = rd_data[s*RULE_W + ID_OFF +: RULE_ID];
      end
    end
  end

  assign last_beat_c = ((32'(beat_q) + 32'd1) * RPC >= 32'(n_q));

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    pkt_d        = pkt_q;
    base_d       = base_q;
    n_d          = n_q;
    beat_d       = beat_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = '0;
    out_valid_d  = 1'b0;
    rule_id_d    = rule_id;
    is_matched_d = is_matched;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pkt_d        = packet_in;
          base_d       = leaf_base;
          n_d          = n_in_c;
          beat_d       = '0;
          rule_id_d    = '0;
          is_matched_d = 1'b0;
          if (n_in_c == '0) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d   = S_FETCH;
            rd_en_d   = 1'b1;
            rd_addr_d = leaf_base;
          end
        end
      end
      S_FETCH: begin
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (hit_c) begin
          rule_id_d    = hit_id_c;
          is_matched_d = 1'b1;
          state_d      = S_DONE;
          out_valid_d  = 1'b1;
        end else if (last_beat_c) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else begin
          beat_d    = beat_q + CNT_W'(1);
          state_d   = S_FETCH;
          rd_en_d   = 1'b1;
          rd_addr_d = base_q + LEAF_ADDR'(beat_q + CNT_W'(1));
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pkt_q      <= '0;
      base_q     <= '0;
      n_q        <= '0;
      beat_q     <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      out_valid  <= 1'b0;
      rule_id    <= '0;
      is_matched <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      base_q     <= base_d;
      n_q        <= n_d;
      beat_q     <= beat_d;
      rd_en      <= rd_en_d;
      rd_addr    <= rd_addr_d;
      out_valid  <= out_valid_d;
      rule_id    <= rule_id_d;
      is_matched <= is_matched_d;
    end
  end

endmodule

// File: rtl/mbt_leaf_match.sv
// Multi-lane leaf-node rule matcher for the MBitTree classifier.
// Each lane is an independent mbt_leaf_lane; lane i owns slice i of every bus.
// Ports: clk, RSTn; request in_valid/in_ready/packet_in/leaf_base/leaf_nrules;
//        rule memory rd_en/rd_addr/rd_data; result out_valid/out_ready/rule_id/is_matched.
module mbt_leaf_match
  import mbt_pkg::*;
#(
  parameter  int unsigned NUM_LANES    = 2,
  parameter  int unsigned PACKET_WIDTH = 104,
  parameter  int unsigned RULE_ID      = 14,
  parameter  int unsigned LEAF_ADDR    = 12,
  parameter  int unsigned RPC          = 4,
  parameter  int unsigned MAX_RULES    = 16,
  localparam int unsigned CNT_W        = cnt_w(MAX_RULES),
  localparam int unsigned WORD_W       = word_w(RPC, PACKET_WIDTH, RULE_ID)
) (
  input  logic                              clk,
  input  logic                              RSTn,
  input  logic [NUM_LANES-1:0]              in_valid,
  output logic [NUM_LANES-1:0]              in_ready,
  input  logic [NUM_LANES*PACKET_WIDTH-1:0] packet_in,
  input  logic [NUM_LANES*LEAF_ADDR-1:0]    leaf_base,
  input  logic [NUM_LANES*CNT_W-1:0]        leaf_nrules,
  output logic [NUM_LANES-1:0]              rd_en,
  output logic [NUM_LANES*LEAF_ADDR-1:0]    rd_addr,
  input  logic [NUM_LANES*WORD_W-1:0]       rd_data,
  output logic [NUM_LANES-1:0]              out_valid,
  input  logic [NUM_LANES-1:0]              out_ready,
  output logic [NUM_LANES*RULE_ID-1:0]      rule_id,
  output logic [NUM_LANES-1:0]              is_matched
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mbt_leaf_lane #(
      .PACKET_WIDTH (PACKET_WIDTH),
      .RULE_ID      (RULE_ID),
      .LEAF_ADDR    (LEAF_ADDR),
      .RPC          (RPC),
      .MAX_RULES    (MAX_RULES)
    ) u_lane (
      .clk         (clk),
      .rst_n       (RSTn),
      .in_valid    (in_valid[g]),
      .in_ready    (in_ready[g]),
      .packet_in   (packet_in[g*PACKET_WIDTH +: PACKET_WIDTH]),
      .leaf_base   (leaf_base[g*LEAF_ADDR +: LEAF_ADDR]),
      .leaf_nrules (leaf_nrules[g*CNT_W +: CNT_W]),
      .rd_en       (rd_en[g]),
      .rd_addr     (rd_addr[g*LEAF_ADDR +: LEAF_ADDR]),
      .rd_data     (rd_data[g*WORD_W +: WORD_W]),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready[g]),
      .rule_id     (rule_id[g*RULE_ID +: RULE_ID]),
      .is_matched  (is_matched[g])
    );
  end

endmodule
